shared_register_arbiter: RTL
============================

# shared_register_arbiter

- Round-robin arbiter and sequencer that shares one 16-bit storage register among `NREQ` requesters.
- The storage register has the same behaviour as the project-03 Register: it loads on a rising edge when load is high and otherwise holds.
- Each requester gets an exclusive read-or-write transaction through a req/gnt/ack handshake.
- The block sits between CPU-side masters (e.g. the CPU and a debug/loader port) and the shared state; it is the only writer of that register.

## Interface

Parameters:
- `WIDTH`, 16, data width of the shared register.
- `NREQ`, 4, number of requesters (2..8).

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `req`  input  NREQ  request per requester; held until `ack`.
- `we`  input  NREQ  per requester: 1 = write, 0 = read. Sampled in the GRANT cycle.
- `wdata`  input  NREQ*WIDTH  write data; requester i uses bits `[i*WIDTH +: WIDTH]`. Sampled in the GRANT cycle.
- `gnt`  output  NREQ  one-hot grant, high for exactly one cycle per transaction.
- `ack`  output  NREQ  one-hot completion, high for exactly one cycle.
- `rdata`  output  WIDTH  current register contents; valid for the owner in its ACK cycle.
- `busy`  output  1  high in GRANT and ACK states.

## Operation

State machine (state register reset value IDLE):
- **IDLE:**
  - If any `req` is high, pick the winner by round-robin search starting at pointer `ptr`, going upward with wrap-around.
  - Latch the winner index into `owner` and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT:**
  - `gnt[owner]`=1.
  - If `req[owner]` is still high:
    - If `we[owner]`=1, load `wdata[owner]` into the register at the edge ending this cycle.
    - Go to ACK.
  - If `req[owner]` is low (abort): no write, no ack, go to IDLE.
  - `ptr` becomes `owner+1` (mod NREQ) in both cases.
- **ACK:**
  - `ack[owner]`=1 and `rdata` = register value, which already includes this transaction's write.
  - Always go to IDLE.

Requester and arbitration rules:
- A requester deasserts `req`, or re-arms it for a new transaction, at the edge that ends its ACK cycle.
- `req` changes in GRANT/ACK from non-owners are ignored until the next IDLE.
- Fairness: any requester holding `req` continuously is granted within NREQ transactions.
- Writes come only from the GRANT path; there is no other load source.
- `rdata` is driven continuously from the register. Outside ACK it is informational only.

Reset values:
- Register = 0, `ptr` = 0, `owner` = 0, state = IDLE.
- `gnt` = 0, `ack` = 0, `busy` = 0, `rdata` = 0.

## Timing

- Transaction latency:
  - `req` high in IDLE cycle n -> `gnt` in cycle n+1 -> `ack` in cycle n+2 -> IDLE in cycle n+3.
  - Peak throughput is one transaction per 3 cycles.
- `gnt`, `ack` and `busy` are decoded from registered state and have no combinational path from `req`.
- Register write takes effect at the rising edge that ends GRANT. `rdata` shows the new value 1 time unit after that edge.
- Simultaneous requests: exactly one grant; the pointer rotates so that the grant after owner k searches from k+1.
- Wrap-around: owner = NREQ-1 sets `ptr` to 0.
- Asynchronous reset:
  - `rst_n` low at any time, including mid-GRANT or mid-ACK, immediately clears all state and outputs to the reset values.
  - An in-flight write that has not reached its GRANT-ending edge is lost.
- Release of `rst_n` is synchronised externally; the block makes no guarantee for release within setup of an edge.

## Test plan

1. **Reset:**
   - Stimulus: `rst_n`=0 mid-run, with register holding 16'hBEEF in GRANT.
   - Required: `gnt`/`ack`/`busy`=0 and `rdata`=0 within 1 time unit, with no clock edge needed. After release, IDLE with `ptr`=0.
2. **Single write/read:**
   - Write: `req[2]`=1, `we[2]`=1, `wdata[2]`=16'h1234. Required: `gnt`=4'b0100 in cycle n+1; `ack`=4'b0100 with `rdata`=16'h1234 in n+2.
   - Read: `req[1]`=1 with `we[1]`=0. Required: `ack[1]` with `rdata`=16'h1234, register unchanged.
3. **Round-robin:**
   - Stimulus: all four `req` held high with writes of 16'h000i, starting from `ptr`=0.
   - Required: grant order 0,1,2,3,0; grants spaced 3 cycles apart; `rdata` in each ACK equals that requester's data.
4. **Wrap and pointer:**
   - Stimulus: after owner 3, `req`=4'b0011.
   - Required: grant goes to 0 (not 1); the next grant goes to 1.
5. **Abort:**
   - Stimulus: `req[0]` drops during its GRANT cycle with `we`=1 and data 16'hFFFF.
   - Required: no ack; register keeps its prior value; return to IDLE; `ptr`=1.
6. **Idle hold:**
   - Stimulus: `req`=0 for 20 cycles after writing 16'hA5A5.
   - Required: `busy`=0 and `rdata`=16'hA5A5 throughout; no `gnt` pulses.

Source files
------------

// File: rtl/shared_register_arbiter_if.sv
// Requester-side bus of the shared register arbiter: per-requester handshake,
// packed write data, and the shared read-back value.
interface shared_register_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       we;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      rdata;
    logic                  busy;

    modport master (
        output req,
        output we,
        output wdata,
        input  gnt,
        input  ack,
        input  rdata,
        input  busy
    );

    modport slave (
        input  req,
        input  we,
        input  wdata,
        output gnt,
        output ack,
        output rdata,
        output busy
    );
endinterface

// File: rtl/shared_register_arbiter.sv
// Round-robin arbiter that serialises read/write transactions from NREQ
// requesters onto a single shared storage register (IDLE -> GRANT -> ACK).
module shared_register_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    shared_register_arbiter_if.slave bus_io
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0]  data_q, data_d;

    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  owner_inc;
    logic [IDX_W:0]    cand;
    logic              any_req;
    logic [WIDTH-1:0]  wdata_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            assign wdata_arr[gi]     = bus_io.wdata[gi*WIDTH +: WIDTH];
            assign bus_io.gnt[gi]    = (state_q == GRANT) && (owner_q == IDX_W'(gi));
            assign bus_io.ack[gi]    = (state_q == ACK)   && (owner_q == IDX_W'(gi));
        end
    endgenerate

    assign bus_io.busy  = (state_q != IDLE);
    assign bus_io.rdata = data_q;

    // First requester found searching upward from ptr_q, wrapping at NREQ.
    always_comb begin
        win_idx = ptr_q;
        any_req = 1'b0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NREQ)) begin
                cand = cand - (IDX_W+1)'(NREQ);
            end
            if (!any_req && bus_io.req[cand[IDX_W-1:0]]) begin
                any_req = 1'b1;
                win_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign owner_inc = (owner_q == IDX_W'(NREQ-1)) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = win_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Pointer advances even on abort so a dropped request cannot starve others.
                ptr_d = owner_inc;
                if (bus_io.req[owner_q]) begin
                    state_d = ACK;
                    if (bus_io.we[owner_q]) begin
                        data_d = wdata_arr[owner_q];
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
        end
    end
endmodule
